// File: rtl/counter_timer_pkg.sv
// Shared types for the counter/timer controller: run modes and FSM states.
package counter_timer_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT  = 2'd0,
    MODE_PERIODIC = 2'd1,
    MODE_PINGPONG = 2'd2
  } mode_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN_UP   = 2'd1,
    RUN_DOWN = 2'd2,
    DONE     = 2'd3
  } state_t;

endpackage

// File: rtl/counter_timer_prescaler.sv
// Step pacer: while enabled, emits one step pulse every p+1 cycles.
module counter_timer_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] p,
  output logic                  step
);

  logic [PRESCALE_W-1:0] cnt;

  // The pulse is decoded from the registered count; the controller registers
  // everything it derives from it, so no input-to-output path is created.
  assign step = enable && (cnt == p);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= step ? '0 : cnt + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/counter_timer_ctrl.sv
// Timer controller: sequences one-shot, periodic and ping-pong counting runs
// and reports terminal events as a Tick pulse and a sticky Done_intr.
module counter_timer_ctrl
  import counter_timer_pkg::*;
#(
  parameter int N          = 17,
  parameter int PRESCALE_W = 8
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  Start,
  input  logic                  Stop,
  input  logic [1:0]            Mode,
  input  logic [N-1:0]          Load_value,
  input  logic [PRESCALE_W-1:0] Prescale,
  input  logic                  Irq_ack,
  output logic [N-1:0]          Count_out,
  output logic                  Busy,
  output logic                  Tick,
  output logic                  Done_intr,
  output state_t                state_dbg
);

  state_t                state;
  logic [1:0]            mode_q;
  logic [N-1:0]          limit_q;
  logic [PRESCALE_W-1:0] pre_q;
  logic                  running;
  logic                  start_ok;
  logic                  step;

  assign running   = (state == RUN_UP) || (state == RUN_DOWN);
  assign start_ok  = Start && ((state == IDLE) || (state == DONE));
  assign state_dbg = state;

  counter_timer_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .enable  (running),
    .clear   (start_ok),
    .p       (pre_q),
    .step    (step)
  );

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      mode_q    <= MODE_ONESHOT;
      limit_q   <= '0;
      pre_q     <= '0;
      Count_out <= '0;
      Busy      <= 1'b0;
      Tick      <= 1'b0;
      Done_intr <= 1'b0;
    end else begin
      Tick <= 1'b0;
      // Ack is applied first so a same-cycle one-shot terminal below wins.
      if (Irq_ack) Done_intr <= 1'b0;

      case (state)
        IDLE, DONE: begin
          if (start_ok) begin
            mode_q    <= Mode;
            limit_q   <= Load_value;
            pre_q     <= Prescale;
            Count_out <= '0;
            Busy      <= 1'b1;
            state     <= RUN_UP;
          end
        end

        RUN_UP: begin
          if (Stop) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else if (step) begin
            if (Count_out != limit_q) begin
              Count_out <= Count_out + {{(N-1){1'b0}}, 1'b1};
            end else begin
              Tick <= 1'b1;
              case (mode_q)
                MODE_PERIODIC: Count_out <= '0;
                MODE_PINGPONG: state     <= RUN_DOWN;
                // Reserved mode 3 falls in here and runs as one-shot.
                default: begin
                  Busy      <= 1'b0;
                  Done_intr <= 1'b1;
                  state     <= DONE;
                end
              endcase
            end
          end
        end

        RUN_DOWN: begin
          if (Stop) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else if (step) begin
            if (Count_out != '0) begin
              Count_out <= Count_out - {{(N-1){1'b0}}, 1'b1};
            end else begin
              Tick  <= 1'b1;
              state <= RUN_UP;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
